// File: rtl/imem_pkg.sv
// Shared types and default geometry for the instruction-memory responder.
// The responder derives its own beat counts from its parameters; these are the defaults.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } imem_state_e;

  localparam int IMEM_DATA_W     = 32;
  localparam int IMEM_BLOCK_BITS = 256;
  localparam int IMEM_BEATS      = IMEM_BLOCK_BITS / IMEM_DATA_W;
  localparam int IMEM_BEATS_LOG2 = $clog2(IMEM_BEATS);

  // Counter width that never collapses to zero bits.
  function automatic int imem_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_storage_ram.sv
// Single-port word storage with registered read; contents are never reset.
module imem_storage_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: single-cycle word writes, block-aligned burst reads.
// The RAM address for each beat is issued one edge ahead so the registered read lands on time.
module imem_responder
  import imem_pkg::*;
#(
  parameter int i_DatabusWidth     = IMEM_DATA_W,
  parameter int iMemoryAddressSize = 16,
  parameter int blockSize          = IMEM_BLOCK_BITS,
  parameter int memAddrBits        = 10,
  parameter int readLatency        = 2
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [iMemoryAddressSize-1:0] address_i,
  input  logic                          makeRequest_i,
  input  logic                          isWrite_i,
  input  logic [i_DatabusWidth-1:0]     dataBus_i,
  output logic [i_DatabusWidth-1:0]     dataBus_o,
  output logic                          enable_o,
  output logic                          busy_o
);

  localparam int BEATS      = blockSize / i_DatabusWidth;
  localparam int BEATS_LOG2 = $clog2(BEATS);
  localparam int BEAT_W     = imem_cnt_w(BEATS);
  localparam int LAT_W      = imem_cnt_w(readLatency);
  localparam logic [memAddrBits-1:0] ALIGN_MASK = ~memAddrBits'((1 << BEATS_LOG2) - 1);

  generate
    if ((blockSize % i_DatabusWidth) != 0 || readLatency < 1) begin : g_param_err
      $error("imem_responder: blockSize must be a multiple of i_DatabusWidth and readLatency >= 1");
    end
  endgenerate

  imem_state_e               r_state, w_state_nxt;
  logic [memAddrBits-1:0]    r_base, w_base_nxt;
  logic [BEAT_W-1:0]         r_beat, w_beat_nxt;
  logic [LAT_W-1:0]          r_lat, w_lat_nxt;
  logic                      w_ram_we;
  logic [memAddrBits-1:0]    w_ram_addr;
  logic [i_DatabusWidth-1:0] w_ram_rdata;
  logic [memAddrBits-1:0]    w_req_addr;
  logic [iMemoryAddressSize-1:0] w_unused_addr_hi;

  // Upper address bits are don't-care: storage aliases modulo its depth.
  assign w_req_addr       = address_i[memAddrBits-1:0];
  assign w_unused_addr_hi = address_i >> memAddrBits;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_beat  <= w_beat_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_beat_nxt  = r_beat;
    w_lat_nxt   = r_lat;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_base;
    case (r_state)
      ST_IDLE: begin
        w_ram_addr = isWrite_i ? w_req_addr : (w_req_addr & ALIGN_MASK);
        if (makeRequest_i) begin
          if (isWrite_i) begin
            w_ram_we = 1'b1;
          end else begin
            w_base_nxt  = w_req_addr & ALIGN_MASK;
            w_beat_nxt  = '0;
            w_lat_nxt   = '0;
            w_state_nxt = (readLatency == 1) ? ST_BURST : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // The final WAIT edge fetches beat 0.
        w_ram_addr = r_base;
        if (r_lat == LAT_W'(readLatency - 2)) w_state_nxt = ST_BURST;
        else                                  w_lat_nxt   = r_lat + 1'b1;
      end
      ST_BURST: begin
        w_ram_addr = r_base + memAddrBits'(r_beat) + memAddrBits'(1);
        if (r_beat == BEAT_W'(BEATS - 1)) begin
          w_state_nxt = ST_IDLE;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt  = r_beat + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  imem_storage_ram #(
    .DATA_W (i_DatabusWidth),
    .ADDR_W (memAddrBits)
  ) u_ram (
    .i_clk   (clock_i),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (dataBus_i),
    .o_rdata (w_ram_rdata)
  );

  assign enable_o  = (r_state == ST_BURST);
  assign busy_o    = (r_state != ST_IDLE);
  assign dataBus_o = enable_o ? w_ram_rdata : '0;

endmodule
